// File: rtl/bundle_prefetch_queue.sv
// Fetch-side prefetch queue: in-order 128-bit bundle reads, PC-tagged queue, flush/redirect with stale-response drop.
// Optional PREFETCH_STATS_EN adds saturating flush_count / starve_count outputs.
module bundle_prefetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [31:0]  flush_pc,
    output logic         mem_req_valid,
    input  logic         mem_req_ready,
    output logic [31:0]  mem_req_addr,
    input  logic         mem_resp_valid,
    input  logic [127:0] mem_resp_bundle,
    output logic         bundle_valid,
    input  logic         bundle_ready,
    output logic [127:0] bundle_out,
    output logic [31:0]  bundle_pc
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]  flush_count,
    output logic [15:0]  starve_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = PTR_W + 2;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [127:0]     data_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [OUT_W-1:0] outstanding, drop_cnt, out_next;
    logic [31:0]      fetch_pc, resp_pc, redirect_pc;
    logic [SUM_W-1:0] live_inflight, committed;
    logic             accept, push, pop, dropping;

    // Live in-flight responses already own a queue slot, so they count against space.
    assign live_inflight = SUM_W'(outstanding) - SUM_W'(drop_cnt);
    assign committed     = SUM_W'(count) + live_inflight;

    assign mem_req_valid = rst && !flush
                           && (outstanding < OUT_W'(MAX_OUTSTANDING))
                           && (committed < SUM_W'(DEPTH));
    assign mem_req_addr  = fetch_pc;

    assign bundle_valid  = (count != '0) && !flush;
    assign bundle_out    = data_q[rd_ptr];
    assign bundle_pc     = pc_q[rd_ptr];

    assign accept      = mem_req_valid && mem_req_ready;
    assign dropping    = mem_resp_valid && (drop_cnt != '0);
    assign push        = mem_resp_valid && (drop_cnt == '0) && !flush;
    assign pop         = bundle_valid && bundle_ready;
    assign out_next    = outstanding + OUT_W'(accept) - OUT_W'(mem_resp_valid);
    assign redirect_pc = flush_pc & 32'hFFFF_FFF0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
        end else begin
            outstanding <= out_next;
            if (flush) begin
                // Everything still in flight after this cycle is stale.
                count    <= '0;
                rd_ptr   <= wr_ptr;
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop_cnt <= out_next;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd16;
                if (dropping)
                    drop_cnt <= drop_cnt - OUT_W'(1);
                if (push) begin
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                    resp_pc <= resp_pc + 32'd16;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)
                    count <= count + CNT_W'(1);
                else if (pop && !push)
                    count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr] <= mem_resp_bundle;
            pc_q[wr_ptr]   <= resp_pc;
        end
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_count  <= '0;
            starve_count <= '0;
        end else begin
            if (flush && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 16'd1;
            if ((count == '0) && bundle_ready && !flush && (starve_count != 16'hFFFF))
                starve_count <= starve_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bundle_prefetch_queue.sv
// Self-checking bench for bundle_prefetch_queue: in-order memory model, expected-PC scoreboard, vector table.
module tb_bundle_prefetch_queue;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [31:0]  flush_pc;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_bundle;
    logic         bundle_valid;
    logic         bundle_ready;
    logic [127:0] bundle_out;
    logic [31:0]  bundle_pc;
`ifdef PREFETCH_STATS_EN
    logic [15:0]  flush_count;
    logic [15:0]  starve_count;
`endif

    always #5 clk = ~clk;

    bundle_prefetch_queue #(
        .DEPTH(4),
        .MAX_OUTSTANDING(2),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .flush_pc(flush_pc),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_bundle(mem_resp_bundle),
        .bundle_valid(bundle_valid),
        .bundle_ready(bundle_ready),
        .bundle_out(bundle_out),
        .bundle_pc(bundle_pc)
`ifdef PREFETCH_STATS_EN
        ,
        .flush_count(flush_count),
        .starve_count(starve_count)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        bit          rdy;
        bit          rv;
        logic [31:0] addr;
        bit          bv;
        logic [31:0] pc;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    int          pops = 0;
    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch;
    logic [31:0] first_pc;
    bit          have_first;
    logic        obs_rv, obs_bv;
    logic [31:0] obs_addr, obs_pc;
    vec_t        tbl[13];

    function automatic logic [127:0] mk(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, ~a, a + 32'h0123_4567, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after negedge, observe, then wait for the next negedge.
    task automatic cycle(input bit rdy, input bit fl, input logic [31:0] fpc);
        logic [31:0] e;
        bundle_ready = rdy;
        flush        = fl;
        flush_pc     = fpc;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_resp_valid  = 1'b1;
            mem_resp_bundle = mk(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            mem_resp_valid  = 1'b0;
            mem_resp_bundle = '0;
        end
        #1;
        obs_rv   = mem_req_valid;
        obs_bv   = bundle_valid;
        obs_addr = mem_req_addr;
        obs_pc   = bundle_pc;
        if (fl) begin
            chk("flush_no_req", mem_req_valid, 1'b0);
            chk("flush_no_pop", bundle_valid, 1'b0);
            exp_q.delete();
            exp_fetch  = {fpc[31:4], 4'b0};
            have_first = 1'b0;
        end
        if (mem_req_valid && mem_req_ready) begin
            chk("req_addr", mem_req_addr, exp_fetch);
            pend.push_back('{mem_req_addr, cyc + lat});
            exp_q.push_back(mem_req_addr);
            exp_fetch = exp_fetch + 32'd16;
        end
        if (bundle_valid && bundle_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual_pc=%h required=no_bundle", bundle_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", bundle_pc, e);
                chk("pop_data", bundle_out, mk(e));
                pops++;
                if (!have_first) begin
                    first_pc   = bundle_pc;
                    have_first = 1'b1;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst             = 1'b0;
        flush           = 1'b0;
        flush_pc        = '0;
        bundle_ready    = 1'b0;
        mem_resp_valid  = 1'b0;
        mem_resp_bundle = '0;
        pend.delete();
        exp_q.delete();
        exp_fetch  = RPC;
        pops       = 0;
        first_pc   = '0;
        have_first = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_req_addr", mem_req_addr, RPC);
        chk("rst_bundle_valid", bundle_valid, 1'b0);
        chk("rst_bundle_out", bundle_out, 128'h0);
        chk("rst_bundle_pc", bundle_pc, 32'h0);
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // rdy, req_valid, req_addr, bundle_valid, bundle_pc ; 1-cycle memory, stall c3..c7
        tbl[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h110, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 32'h120, 1'b1, 32'h100};
        tbl[3]  = '{1'b0, 1'b1, 32'h130, 1'b1, 32'h110};
        tbl[4]  = '{1'b0, 1'b1, 32'h140, 1'b1, 32'h110};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h110};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h110};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h110};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h110};
        tbl[9]  = '{1'b1, 1'b1, 32'h150, 1'b1, 32'h120};
        tbl[10] = '{1'b1, 1'b1, 32'h160, 1'b1, 32'h130};
        tbl[11] = '{1'b1, 1'b1, 32'h170, 1'b1, 32'h140};
        tbl[12] = '{1'b1, 1'b1, 32'h180, 1'b1, 32'h150};

        mem_req_ready = 1'b1;
        lat = 1;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rdy, 1'b0, 32'h0);
            chk($sformatf("vec%0d_req_valid", i), obs_rv, tbl[i].rv);
            if (tbl[i].rv)
                chk($sformatf("vec%0d_req_addr", i), obs_addr, tbl[i].addr);
            chk($sformatf("vec%0d_bundle_valid", i), obs_bv, tbl[i].bv);
            if (tbl[i].bv)
                chk($sformatf("vec%0d_bundle_pc", i), obs_pc, tbl[i].pc);
        end

        // Build up three queued entries, then reset asynchronously between clock edges.
        cycle(1'b0, 1'b0, 32'h0);
        chk("pre_reset_valid", bundle_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_req_valid", mem_req_valid, 1'b0);
        chk("async_req_addr", mem_req_addr, RPC);
        chk("async_bundle_valid", bundle_valid, 1'b0);
        chk("async_bundle_out", bundle_out, 128'h0);
        chk("async_bundle_pc", bundle_pc, 32'h0);
        @(negedge clk);

        // Ten-cycle stall from reset: queue fills, head holds, requests stop; then drain in order.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (i >= 2) begin
                chk("stall_head_valid", obs_bv, 1'b1);
                chk("stall_head_pc", obs_pc, 32'h100);
            end
            if (i >= 4)
                chk("stall_no_req", obs_rv, 1'b0);
        end
        for (int i = 0; i < 12; i++)
            cycle(1'b1, 1'b0, 32'h0);
        chk("drain_count", pops, 12);

        // Three-cycle memory, flush with two reads in flight.
        lat = 3;
        do_reset();
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h2004);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redirect_addr_f1", obs_addr, 32'h2000);
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b0, 32'h0);
        chk("redirect_first_pc", first_pc, 32'h2000);

        // Flush coinciding with a live response and a ready consumer.
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h3000);
        cycle(1'b1, 1'b0, 32'h0);
        chk("flush_queue_empty", obs_bv, 1'b0);
        chk("flush_f1_req_valid", obs_rv, 1'b1);
        chk("flush_f1_req_addr", obs_addr, 32'h3000);
        cycle(1'b1, 1'b0, 32'h0);
        chk("flush_f2_bundle_valid", obs_bv, 1'b0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("flush_f3_bundle_valid", obs_bv, 1'b1);
        chk("flush_f3_bundle_pc", obs_pc, 32'h3000);
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 1'b0, 32'h0);

`ifdef PREFETCH_STATS_EN
        do_reset();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 32'h4000);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b0, 32'h0);
        chk("stats_flush_count", flush_count, 16'd3);
        chk("stats_starve_count", starve_count, 16'd5);
        mem_req_ready = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
